// File: rtl/pad_pkg.sv
// rtl/pad_pkg.sv - shared types, pad-mode constants and tap bounds check for window_pad_kxk
package pad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } pad_state_t;

    localparam logic PAD_ZERO  = 1'b0;
    localparam logic PAD_CONST = 1'b1;

    // Dimensions are zero-extended to this width; two spare bits keep the signed
    // offset arithmetic free of wrap-around for any image side up to 2^16-1.
    localparam int PKG_DIM_W = 16;
    localparam int PKG_SW    = PKG_DIM_W + 2;
    typedef logic signed [PKG_SW-1:0] pad_sdim_t;

    function automatic logic tap_oob(
        input logic [PKG_DIM_W-1:0] row,
        input logic [PKG_DIM_W-1:0] col,
        input int                   dr,
        input int                   dc,
        input logic [PKG_DIM_W-1:0] w,
        input logic [PKG_DIM_W-1:0] h
    );
        pad_sdim_t rr;
        pad_sdim_t cc;
        pad_sdim_t sw;
        pad_sdim_t sh;
        rr = pad_sdim_t'({2'b00, row}) + pad_sdim_t'(dr);
        cc = pad_sdim_t'({2'b00, col}) + pad_sdim_t'(dc);
        sw = pad_sdim_t'({2'b00, w});
        sh = pad_sdim_t'({2'b00, h});
        return rr[PKG_SW-1] || (rr >= sh) || cc[PKG_SW-1] || (cc >= sw);
    endfunction

endpackage

// File: rtl/pad_pos_counter.sv
// rtl/pad_pos_counter.sv - raster row/col position of the window centre with last-pixel flag
module pad_pos_counter #(
    parameter int DIM_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [DIM_W-1:0] i_img_w,
    input  logic [DIM_W-1:0] i_img_h,
    output logic [DIM_W-1:0] o_row,
    output logic [DIM_W-1:0] o_col,
    output logic             o_last
);

    logic [DIM_W-1:0] r_row;
    logic [DIM_W-1:0] r_col;
    logic             w_col_last;
    logic             w_row_last;

    assign w_col_last = (r_col == i_img_w - DIM_W'(1));
    assign w_row_last = (r_row == i_img_h - DIM_W'(1));
    assign o_last     = w_col_last && w_row_last;
    assign o_row      = r_row;
    assign o_col      = r_col;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_en) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + DIM_W'(1);
            end else begin
                r_col <= r_col + DIM_W'(1);
            end
        end
    end

endmodule

// File: rtl/window_pad_kxk.sv
// rtl/window_pad_kxk.sv - KxK sliding window former with border padding, one window per centre pixel
module window_pad_kxk
    import pad_pkg::*;
#(
    parameter int K     = 7,
    parameter int DW    = 8,
    parameter int DIM_W = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [K*DW-1:0]     col_i,
    input  logic                col_valid_i,
    input  logic [DIM_W-1:0]    img_w_i,
    input  logic [DIM_W-1:0]    img_h_i,
    input  logic                pad_mode_i,
    input  logic [DW-1:0]       pad_val_i,
    output logic [K*K*DW-1:0]   win_o,
    output logic                win_valid_o,
    output logic                frame_done_o
);

    localparam int R      = (K - 1) / 2;
    localparam int FILL_W = $clog2(K);

    pad_state_t         r_state;
    pad_state_t         w_state_nxt;
    logic [FILL_W-1:0]  r_fill_cnt;
    logic [DIM_W-1:0]   r_img_w;
    logic [DIM_W-1:0]   r_img_h;
    logic               r_pad_mode;
    logic [DW-1:0]      r_pad_val;
    logic [K*K*DW-1:0]  r_win;
    logic [K*K*DW-1:0]  w_shift;
    logic [K*K*DW-1:0]  w_masked;
    logic [DIM_W-1:0]   w_row;
    logic [DIM_W-1:0]   w_col;
    logic               w_last;
    logic               w_fill_beat;
    logic               w_data_beat;
    logic               w_cfg_load;
    logic               w_fill_end;
    logic [DW-1:0]      w_pad;

    assign w_fill_end = (r_fill_cnt == FILL_W'(R - 1));
    assign w_pad      = (r_pad_mode == PAD_CONST) ? r_pad_val : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // The IDLE->FILL beat is the first of the R priming beats.
    always_comb begin
        w_state_nxt = r_state;
        w_fill_beat = 1'b0;
        w_data_beat = 1'b0;
        w_cfg_load  = 1'b0;
        case (r_state)
            ST_IDLE: if (col_valid_i) begin
                w_cfg_load  = 1'b1;
                w_fill_beat = 1'b1;
                w_state_nxt = w_fill_end ? ST_DATA : ST_FILL;
            end
            ST_FILL: if (col_valid_i) begin
                w_fill_beat = 1'b1;
                if (w_fill_end) w_state_nxt = ST_DATA;
            end
            ST_DATA: if (col_valid_i) begin
                w_data_beat = 1'b1;
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fill_cnt <= '0;
            r_img_w    <= '0;
            r_img_h    <= '0;
            r_pad_mode <= PAD_ZERO;
            r_pad_val  <= '0;
            r_win      <= '0;
        end else begin
            if (w_fill_beat)             r_fill_cnt <= r_fill_cnt + FILL_W'(1);
            else if (r_state != ST_FILL) r_fill_cnt <= '0;
            if (w_cfg_load) begin
                r_img_w    <= img_w_i;
                r_img_h    <= img_h_i;
                r_pad_mode <= pad_mode_i;
                r_pad_val  <= pad_val_i;
            end
            if (w_fill_beat || w_data_beat) r_win <= w_shift;
        end
    end

    pad_pos_counter #(.DIM_W(DIM_W)) u_pos (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (r_state != ST_DATA),
        .i_en    (w_data_beat),
        .i_img_w (r_img_w),
        .i_img_h (r_img_h),
        .o_row   (w_row),
        .o_col   (w_col),
        .o_last  (w_last)
    );

    // Masking works on the post-shift window so the incoming column is part of this beat's output.
    for (genvar gr = 0; gr < K; gr++) begin : g_row
        for (genvar gc = 0; gc < K; gc++) begin : g_col
            localparam int DR = gr - R;
            localparam int DC = gc - R;
            logic w_oob;
            if (gc < K - 1) begin : g_mid
                assign w_shift[(gr*K+gc)*DW +: DW] = r_win[(gr*K+gc+1)*DW +: DW];
            end else begin : g_in
                assign w_shift[(gr*K+gc)*DW +: DW] = col_i[(K-1-gr)*DW +: DW];
            end
            assign w_oob = tap_oob(PKG_DIM_W'(w_row), PKG_DIM_W'(w_col), DR, DC,
                                   PKG_DIM_W'(r_img_w), PKG_DIM_W'(r_img_h));
            assign w_masked[(gr*K+gc)*DW +: DW] = w_oob ? w_pad : w_shift[(gr*K+gc)*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_o        <= '0;
            win_valid_o  <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            win_valid_o  <= w_data_beat;
            frame_done_o <= w_data_beat && w_last;
            if (w_data_beat) win_o <= w_masked;
        end
    end

endmodule

// File: tb/tb_window_pad_kxk.sv
// tb/tb_window_pad_kxk.sv - scoreboard bench for window_pad_kxk against an image-level padding model
module tb_window_pad_kxk;

    localparam int K     = 5;
    localparam int DW    = 8;
    localparam int DIM_W = 9;
    localparam int R     = (K - 1) / 2;
    localparam int KKW   = K * K * DW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [K*DW-1:0]   col_i = '0;
    logic              col_valid_i = 1'b0;
    logic [DIM_W-1:0]  img_w_i = DIM_W'(K);
    logic [DIM_W-1:0]  img_h_i = DIM_W'(K);
    logic              pad_mode_i = 1'b0;
    logic [DW-1:0]     pad_val_i = '0;
    logic [KKW-1:0]    win_o;
    logic              win_valid_o;
    logic              frame_done_o;

    typedef struct {
        logic [KKW-1:0] win;
        logic           done;
    } exp_t;

    exp_t           exp_q[$];
    int             n_cmp = 0;
    int             n_bad = 0;
    logic [DW-1:0]  img [0:15][0:15];
    int             cur_w;
    int             cur_h;
    logic           cur_mode;
    logic [DW-1:0]  cur_pad;
    logic           prev_valid = 1'b0;
    logic [KKW-1:0] last_win = '0;
    bit             started = 1'b0;

    window_pad_kxk #(.K(K), .DW(DW), .DIM_W(DIM_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .col_i        (col_i),
        .col_valid_i  (col_valid_i),
        .img_w_i      (img_w_i),
        .img_h_i      (img_h_i),
        .pad_mode_i   (pad_mode_i),
        .pad_val_i    (pad_val_i),
        .win_o        (win_o),
        .win_valid_o  (win_valid_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    // Column for raster position p: slice s holds image row (row + R - s); rows outside the image carry junk.
    function automatic logic [K*DW-1:0] make_col(input int p);
        logic [K*DW-1:0] v;
        int row, col, rr;
        row = p / cur_w;
        col = p % cur_w;
        for (int s = 0; s < K; s++) begin
            rr = row + R - s;
            if (p < cur_w * cur_h && rr >= 0 && rr < cur_h) v[s*DW +: DW] = img[rr][col];
            else                                            v[s*DW +: DW] = DW'($urandom);
        end
        return v;
    endfunction

    function automatic exp_t make_exp(input int p);
        exp_t e;
        int row, col, rr, cc;
        row = p / cur_w;
        col = p % cur_w;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                rr = row + r - R;
                cc = col + c - R;
                if (rr < 0 || rr >= cur_h || cc < 0 || cc >= cur_w)
                    e.win[(r*K+c)*DW +: DW] = cur_mode ? cur_pad : '0;
                else
                    e.win[(r*K+c)*DW +: DW] = img[rr][cc];
            end
        end
        e.done = (p == cur_w * cur_h - 1);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [K*DW-1:0] v, input int gap);
        col_i       = v;
        col_valid_i = 1'b1;
        step();
        col_valid_i = 1'b0;
        col_i       = ~v;
        repeat (gap) step();
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            step();
            t++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_%s: %0d windows still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // gap_mode: 0 none, 1 one idle cycle after every beat, 2 random 0..2 idle cycles.
    task automatic run_frame(input int w, input int h, input logic mode, input logic [DW-1:0] padv,
                             input int gap_mode, input int abort_after, input bit done_garbage,
                             input string name);
        int n_beats, gap;
        cur_w = w;
        cur_h = h;
        cur_mode = mode;
        cur_pad = padv;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                img[r][c] = DW'($urandom);
        for (int p = 0; p < ((abort_after > 0) ? abort_after : w * h); p++)
            exp_q.push_back(make_exp(p));
        img_w_i    = DIM_W'(w);
        img_h_i    = DIM_W'(h);
        pad_mode_i = mode;
        pad_val_i  = padv;
        n_beats = (abort_after > 0) ? R + abort_after : w * h + R;
        for (int j = 0; j < n_beats; j++) begin
            gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
            if (done_garbage && j == n_beats - 1) gap = 0;
            beat(make_col(j), gap);
            if (j == 0) begin
                img_w_i    = DIM_W'($urandom);
                img_h_i    = DIM_W'($urandom);
                pad_mode_i = ~mode;
                pad_val_i  = ~padv;
            end
        end
        if (abort_after > 0) begin
            rst_n = 1'b0;
            step();
            rst_n    = 1'b1;
            last_win = '0;
            @(negedge clk);
            n_cmp++;
            if (win_o !== '0) begin
                n_bad++;
                $display("FAIL abort_win: got %h, required 0", win_o);
            end
            n_cmp++;
            if (win_valid_o !== 1'b0 || frame_done_o !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_flags: valid=%b done=%b, required 0 0", win_valid_o, frame_done_o);
            end
            step();
        end else if (done_garbage) begin
            col_i       = {K{8'h5A}};
            col_valid_i = 1'b1;
            step();
            col_valid_i = 1'b0;
        end else begin
            step();
        end
        wait_drain(name);
    endtask

    always @(posedge clk) prev_valid <= col_valid_i;

    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            if (win_valid_o) begin
                n_cmp++;
                if (!prev_valid) begin
                    n_bad++;
                    $display("FAIL stall_gate: win_valid_o=1 after col_valid_i=0, required 0");
                end
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_window: got %h, required no window", win_o);
                end else begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (win_o !== e.win) begin
                        n_bad++;
                        $display("FAIL window: got %h, required %h", win_o, e.win);
                    end
                    n_cmp++;
                    if (frame_done_o !== e.done) begin
                        n_bad++;
                        $display("FAIL frame_done: got %b, required %b", frame_done_o, e.done);
                    end
                end
                last_win = win_o;
            end else begin
                n_cmp++;
                if (frame_done_o !== 1'b0) begin
                    n_bad++;
                    $display("FAIL done_no_valid: frame_done_o=%b, required 0", frame_done_o);
                end
                n_cmp++;
                if (win_o !== last_win) begin
                    n_bad++;
                    $display("FAIL win_hold: got %h, required %h", win_o, last_win);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, h;
        rst_n = 1'b0;
        repeat (3) step();
        @(negedge clk);
        n_cmp++;
        if (win_o !== '0 || win_valid_o !== 1'b0 || frame_done_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: win=%h valid=%b done=%b, required 0 0 0",
                     win_o, win_valid_o, frame_done_o);
        end
        step();
        rst_n   = 1'b1;
        started = 1'b1;
        step();

        run_frame(5, 5, 1'b0, 8'h00, 0, 0, 1'b0, "min_zero");
        run_frame(6, 5, 1'b1, 8'h3C, 1, 0, 1'b0, "stall_toggle");
        run_frame(6, 5, 1'b1, 8'h3C, 0, 0, 1'b0, "no_stall");
        run_frame(5, 5, 1'b1, 8'hAA, 0, 0, 1'b1, "b2b_first");
        run_frame(7, 7, 1'b0, 8'h00, 0, 0, 1'b0, "b2b_second");
        run_frame(7, 7, 1'b1, 8'h77, 0, 6, 1'b0, "abort");
        run_frame(7, 7, 1'b1, 8'h77, 2, 0, 1'b0, "after_abort");
        for (int i = 0; i < 3; i++) begin
            w = $urandom_range(K, 12);
            h = $urandom_range(K, 12);
            run_frame(w, h, 1'($urandom), DW'($urandom), 2, 0, 1'($urandom), "random");
        end

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
